// File: rtl/pipe_stage.sv
// pipe_stage: single-beat valid/ready pipeline register with flush and a
// saturating back-pressure counter. Define PIPE_STAGE_SKID_EN to add a
// one-entry skid buffer and a registered in_ready.
module pipe_stage #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned NUM_DATA = 5,
  parameter int unsigned CTRL_W   = 9,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [CTRL_W-1:0]          in_ctrl,
  input  logic [NUM_DATA*DATA_W-1:0] in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [CTRL_W-1:0]          out_ctrl,
  output logic [NUM_DATA*DATA_W-1:0] out_data,
  input  logic                       flush,
  input  logic                       cnt_clr,
  output logic [CNT_W-1:0]           stall_cnt
);

  localparam int unsigned BUS_W = NUM_DATA * DATA_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic              in_xfer_c;
  logic              main_valid_n;
  logic [CTRL_W-1:0] main_ctrl_n;
  logic [BUS_W-1:0]  main_data_n;

  // Saturating count of cycles where a held beat is back-pressured
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (cnt_clr) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != CNT_MAX)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

`ifdef PIPE_STAGE_SKID_EN

  logic              skid_valid;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [BUS_W-1:0]  skid_data;
  logic              skid_valid_n;
  logic [CTRL_W-1:0] skid_ctrl_n;
  logic [BUS_W-1:0]  skid_data_n;

  assign in_xfer_c = in_valid & in_ready;

  // Next state for main and skid entries; skid only fills behind a stalled main
  always_comb begin
    main_valid_n = out_valid;
    main_ctrl_n  = out_ctrl;
    main_data_n  = out_data;
    skid_valid_n = skid_valid;
    skid_ctrl_n  = skid_ctrl;
    skid_data_n  = skid_data;
    if (flush) begin
      main_valid_n = 1'b0;
      main_ctrl_n  = '0;
      skid_valid_n = 1'b0;
    end else if (skid_valid) begin
      if (out_ready) begin
        main_valid_n = 1'b1;
        main_ctrl_n  = skid_ctrl;
        main_data_n  = skid_data;
        skid_valid_n = 1'b0;
      end
    end else if (out_valid && !out_ready) begin
      if (in_xfer_c) begin
        skid_valid_n = 1'b1;
        skid_ctrl_n  = in_ctrl;
        skid_data_n  = in_data;
      end
    end else if (in_xfer_c) begin
      main_valid_n = 1'b1;
      main_ctrl_n  = in_ctrl;
      main_data_n  = in_data;
    end else begin
      main_valid_n = 1'b0;
      main_ctrl_n  = '0;
    end
  end

  // Main/skid registers; in_ready is registered from the next skid state
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid  <= 1'b0;
      out_ctrl   <= '0;
      out_data   <= '0;
      skid_valid <= 1'b0;
      skid_ctrl  <= '0;
      skid_data  <= '0;
      in_ready   <= 1'b1;
    end else begin
      out_valid  <= main_valid_n;
      out_ctrl   <= main_ctrl_n;
      out_data   <= main_data_n;
      skid_valid <= skid_valid_n;
      skid_ctrl  <= skid_ctrl_n;
      skid_data  <= skid_data_n;
      in_ready   <= ~skid_valid_n;
    end
  end

`else

  logic out_xfer_c;

  assign in_ready   = out_ready | ~out_valid;
  assign in_xfer_c  = in_valid & in_ready;
  assign out_xfer_c = out_valid & out_ready;

  // Next state for the single register; draining without refill leaves a bubble
  always_comb begin
    main_valid_n = out_valid;
    main_ctrl_n  = out_ctrl;
    main_data_n  = out_data;
    if (flush) begin
      main_valid_n = 1'b0;
      main_ctrl_n  = '0;
    end else if (in_xfer_c) begin
      main_valid_n = 1'b1;
      main_ctrl_n  = in_ctrl;
      main_data_n  = in_data;
    end else if (out_xfer_c) begin
      main_valid_n = 1'b0;
      main_ctrl_n  = '0;
    end
  end

  // Pipeline register
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_ctrl  <= '0;
      out_data  <= '0;
    end else begin
      out_valid <= main_valid_n;
      out_ctrl  <= main_ctrl_n;
      out_data  <= main_data_n;
    end
  end

`endif

endmodule

// File: tb/tb_pipe_stage.sv
// tb_pipe_stage: directed + randomized bench for pipe_stage, checked against
// a queue-based model of the beats held in the stage.
module tb_pipe_stage;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned NUM_DATA = 5;
  localparam int unsigned CTRL_W   = 9;
  localparam int unsigned CNT_W    = 4;
  localparam int unsigned BUS_W    = NUM_DATA * DATA_W;
  localparam int          CNT_MAX  = (1 << CNT_W) - 1;
`ifdef PIPE_STAGE_SKID_EN
  localparam int          DEPTH    = 2;
`else
  localparam int          DEPTH    = 1;
`endif

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [BUS_W-1:0]  data;
  } beat_t;

  logic              clk;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [BUS_W-1:0]  in_data;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [BUS_W-1:0]  out_data;
  logic              flush;
  logic              cnt_clr;
  logic [CNT_W-1:0]  stall_cnt;

  int    n_tests;
  int    n_fail;
  beat_t q[$];
  int    m_cnt;

  pipe_stage #(
    .DATA_W  (DATA_W),
    .NUM_DATA(NUM_DATA),
    .CTRL_W  (CTRL_W),
    .CNT_W   (CNT_W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_ctrl  (in_ctrl),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_ctrl (out_ctrl),
    .out_data (out_data),
    .flush    (flush),
    .cnt_clr  (cnt_clr),
    .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [BUS_W-1:0] got,
                       input logic [BUS_W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // The stage can take a beat while it holds fewer than DEPTH beats;
  // without skid storage it can also refill while draining.
  function automatic logic model_ready(input logic ordy);
    if (DEPTH == 2) return q.size() < 2;
    return (q.size() == 0) || ordy;
  endfunction

  function automatic logic [BUS_W-1:0] rand_bus();
    logic [BUS_W-1:0] b;
    for (int k = 0; k < int'(NUM_DATA); k++) b[k*DATA_W +: DATA_W] = DATA_W'($urandom);
    return b;
  endfunction

  // One clock cycle: drive, compare against model, advance model at the edge
  task automatic step(input logic v, input logic [CTRL_W-1:0] c, input logic [BUS_W-1:0] d,
                      input logic ordy, input logic fl, input logic clr, input logic rst);
    logic rdy;
    in_valid  = v;
    in_ctrl   = c;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    cnt_clr   = clr;
    reset     = rst;
    #1;
    rdy = model_ready(ordy);
    check("in_ready", BUS_W'(in_ready), BUS_W'(rdy));
    check("out_valid", BUS_W'(out_valid), BUS_W'(q.size() > 0));
    check("out_ctrl", BUS_W'(out_ctrl), (q.size() > 0) ? BUS_W'(q[0].ctrl) : '0);
    if (q.size() > 0) check("out_data", out_data, q[0].data);
    check("stall_cnt", BUS_W'(stall_cnt), BUS_W'(m_cnt));
    @(posedge clk);
    if (rst) begin
      q.delete();
      m_cnt = 0;
    end else begin
      if (clr) m_cnt = 0;
      else if ((q.size() > 0) && !ordy && (m_cnt < CNT_MAX)) m_cnt++;
      if (fl) begin
        q.delete();
      end else begin
        if ((q.size() > 0) && ordy) void'(q.pop_front());
        if (v && rdy) q.push_back('{ctrl: c, data: d});
      end
    end
    @(negedge clk);
  endtask

  initial begin
    logic [BUS_W-1:0] d;
    n_tests   = 0;
    n_fail    = 0;
    m_cnt     = 0;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_ctrl   = '0;
    in_data   = '0;
    out_ready = 1'b0;
    flush     = 1'b0;
    cnt_clr   = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_valid", BUS_W'(out_valid), '0);
    check("rst_ctrl", BUS_W'(out_ctrl), '0);
    check("rst_data", out_data, '0);
    check("rst_cnt", BUS_W'(stall_cnt), '0);
    check("rst_ready", BUS_W'(in_ready), BUS_W'(1));

    // Streaming lane0 = 1..4
    for (int i = 1; i <= 4; i++) begin
      d = rand_bus();
      d[DATA_W-1:0] = DATA_W'(i);
      step(1'b1, CTRL_W'($urandom), d, 1'b1, 1'b0, 1'b0, 1'b0);
    end
    check("stream_lane0", BUS_W'(out_data[DATA_W-1:0]), BUS_W'(4));
    step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("stream_cnt", BUS_W'(stall_cnt), '0);

    // Back-pressure: 0xA5 held for 3 cycles while 0x5A is offered
    step(1'b0, '0, '0, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 9'h011, BUS_W'(32'hA5), 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 9'h022, BUS_W'(32'h5A), 1'b0, 1'b0, 1'b0, 1'b0);
    check("bp_data", out_data, BUS_W'(32'hA5));
    check("bp_cnt", BUS_W'(stall_cnt), BUS_W'(3));
    for (int i = 0; i < 3; i++) step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, 1'b0);

    // Flush of a stalled all-ones control beat
    step(1'b1, 9'h1FF, rand_bus(), 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 9'h1FF, rand_bus(), 1'b0, 1'b1, 1'b0, 1'b0);
    in_valid = 1'b0;
    flush    = 1'b0;
    #1;
    check("flush_valid", BUS_W'(out_valid), '0);
    check("flush_ctrl", BUS_W'(out_ctrl), '0);
    check("flush_ready", BUS_W'(in_ready), BUS_W'(1));
    for (int i = 0; i < 2; i++) step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, 1'b0);

    // Bubble carries zero control
    step(1'b0, 9'h1FF, rand_bus(), 1'b1, 1'b0, 1'b0, 1'b0);
    check("bubble_ctrl", BUS_W'(out_ctrl), '0);

    // Saturation, then clear racing a stall cycle
    step(1'b1, 9'h0AA, rand_bus(), 1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("sat_cnt", BUS_W'(stall_cnt), BUS_W'(15));
    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("clr_cnt", BUS_W'(stall_cnt), '0);

    // Reset in the middle of a stall with pending beats
    for (int i = 0; i < 2; i++) step(1'b1, 9'h155, rand_bus(), 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 9'h0F0, rand_bus(), 1'b0, 1'b0, 1'b0, 1'b1);
    check("rst2_valid", BUS_W'(out_valid), '0);
    check("rst2_ctrl", BUS_W'(out_ctrl), '0);
    check("rst2_data", out_data, '0);
    check("rst2_cnt", BUS_W'(stall_cnt), '0);
    for (int i = 0; i < 3; i++) step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 3) != 0, CTRL_W'($urandom), rand_bus(),
           $urandom_range(0, 3) != 0, $urandom_range(0, 24) == 0,
           $urandom_range(0, 29) == 0, $urandom_range(0, 149) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_stage.md
PIPE_STAGE -- requirements
Module: pipe_stage

Interface
REQ-001 Parameter DATA_W, default 32: width of each data lane.
REQ-002 Parameter NUM_DATA, default 5: number of data lanes (A, B, PC, rs2 data, instr).
REQ-003 Parameter CTRL_W, default 9: control width (mem_read, mem_write, mem_to_reg, jumpl, branch, 4-bit alu select).
REQ-004 Parameter CNT_W, default 16: stall counter width.
REQ-005 clk  in  1  sole clock; all state updates on rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 in_valid  in  1  upstream beat present.
REQ-008 in_ready  out  1  stage accepts beat this cycle.
REQ-009 in_ctrl  in  CTRL_W  upstream control bits.
REQ-010 in_data  in  NUM_DATA*DATA_W  upstream lanes; lane k is bits [k*DATA_W +: DATA_W].
REQ-011 out_valid  out  1  registered beat present.
REQ-012 out_ready  in  1  downstream accepts beat.
REQ-013 out_ctrl  out  CTRL_W  registered control.
REQ-014 out_data  out  NUM_DATA*DATA_W  registered lanes.
REQ-015 flush  in  1  kill all held and incoming beats (branch/jump redirect).
REQ-016 cnt_clr  in  1  clear stall counter.
REQ-017 stall_cnt  out  CNT_W  count of back-pressured cycles.

Function
REQ-018 Input transfer = in_valid & in_ready; output transfer = out_valid & out_ready.
REQ-019 Latency: a beat accepted in cycle N appears on out_* in cycle N+1 when the stage is empty or draining.
REQ-020 Beats leave in acceptance order; no beat is duplicated or dropped except by flush.
REQ-021 While out_valid=1 and out_ready=0, out_ctrl and out_data hold stable.
REQ-022 out_ctrl is all-zero in every cycle out_valid=0 (bubble carries no side effects).
REQ-023 out_data is don't-care when out_valid=0 but updates only on an accepted beat.
REQ-024 flush=1: next cycle out_valid=0, out_ctrl=0, skid entry (if present) invalid; beat offered in the flush cycle is discarded.
REQ-025 flush takes priority over all transfers; reset takes priority over flush.
REQ-026 stall_cnt increments by 1 in each cycle with out_valid=1 and out_ready=0, saturating at 2^CNT_W-1.
REQ-027 cnt_clr=1 sets stall_cnt to 0 next cycle; it wins over a simultaneous increment.

Reset
REQ-028 reset=1 at a clock edge: out_valid=0, out_ctrl=0, out_data=0 (all lanes), skid invalid, stall_cnt=0.
REQ-029 in_ready is 1 in the first cycle after reset deasserts.
REQ-030 reset asserted mid-stall discards both main and skid beats with no output transfer.

Configuration
REQ-031 Macro PIPE_STAGE_SKID_EN selects the ready path.
REQ-032 Without PIPE_STAGE_SKID_EN: in_ready = out_ready | ~out_valid (combinational); single register, no skid storage.
REQ-033 With PIPE_STAGE_SKID_EN: in_ready is a flop output equal to ~skid_valid; a beat accepted while main is stalled goes into a one-entry skid buffer.
REQ-034 With skid: on output transfer, skid beat moves to main next cycle and in_ready returns to 1 the same next cycle; full throughput of one beat per cycle is preserved.
REQ-035 With skid: out_ready never combinationally reaches in_ready.

Verification
REQ-036 Streaming: in_valid=1, out_ready=1, lane0 = 1,2,3,4 in consecutive cycles -> out_data lane0 = 1,2,3,4 one cycle later, out_valid=1 continuously, stall_cnt=0.
REQ-037 Back-pressure: out_ready=0 for 3 cycles holding beat 0xA5 -> out_data stable at 0xA5, stall_cnt=3; with skid, next beat 0x5A captured, in_ready=0, then 0xA5, 0x5A emitted in order after out_ready=1.
REQ-038 Flush: beat ctrl=0x1FF valid and stalled, flush=1 one cycle -> next cycle out_valid=0, out_ctrl=0x000, in_ready=1, stale beat never emitted.
REQ-039 Bubble: in_valid=0 with in_ctrl=0x1FF, out_ready=1 -> out_valid=0, out_ctrl=0.
REQ-040 Saturation/reset: CNT_W=4, stall 20 cycles -> stall_cnt=15; cnt_clr together with a stall cycle -> 0; reset during stall -> all outputs 0, lane values 0.
